// File: rtl/put_unit_if.sv
// Request and register-file write channels of the PUT pipeline.
// The slave modport is the put_unit side; master is the requester/register-file side.
interface put_unit_if;
  logic       req_valid;
  logic       req_ready;
  logic [2:0] req_idx;
  logic [2:0] req_dest;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [7:0] wr_data;
  logic       wr_ready;

  modport slave (
    input  req_valid, req_idx, req_dest, wr_ready,
    output req_ready, wr_en, wr_addr, wr_data
  );

  modport master (
    output req_valid, req_idx, req_dest, wr_ready,
    input  req_ready, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/put_unit.sv
// Two-stage PUT pipeline: S1 presents an index to the external constant table,
// S2 holds the looked-up constant as a register-file write until it is accepted.
module put_unit (
  input  logic             Clk,
  input  logic             Reset,
  put_unit_if.slave        bus,
  input  logic             problem_ld,
  input  logic [1:0]       problem_in,
  output logic [1:0]       problem,
  output logic [2:0]       Num_put_idx,
  input  logic [7:0]       Num_to_put,
  output logic             busy,
  output logic             err_problem,
  output logic [7:0]       put_count
);

  logic       s1_valid_q, s1_valid_d;
  logic [2:0] s1_idx_q, s1_idx_d;
  logic [2:0] s1_dest_q, s1_dest_d;
  logic       s2_valid_q, s2_valid_d;
  logic [2:0] s2_addr_q, s2_addr_d;
  logic [7:0] s2_data_q, s2_data_d;
  logic [1:0] problem_q, problem_d;
  logic       err_q, err_d;
  logic [7:0] count_q, count_d;

  logic s2_free, s1_adv, accept, wr_done, busy_int;

  assign s2_free  = !s2_valid_q || bus.wr_ready;
  assign s1_adv   = s1_valid_q && s2_free;
  assign busy_int = s1_valid_q || s2_valid_q;
  assign wr_done  = s2_valid_q && bus.wr_ready;
  // Accept in the same cycle S1 drains, so back-to-back requests see no bubble.
  assign bus.req_ready = !Reset && (!s1_valid_q || s1_adv);
  assign accept        = bus.req_valid && bus.req_ready;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_idx_d   = s1_idx_q;
    s1_dest_d  = s1_dest_q;
    s2_valid_d = s2_valid_q;
    s2_addr_d  = s2_addr_q;
    s2_data_d  = s2_data_q;
    problem_d  = problem_q;
    err_d      = err_q;
    count_d    = count_q;

    if (accept) begin
      s1_valid_d = 1'b1;
      s1_idx_d   = bus.req_idx;
      s1_dest_d  = bus.req_dest;
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end

    if (s1_adv) begin
      s2_valid_d = 1'b1;
      s2_addr_d  = s1_dest_q;
      s2_data_d  = Num_to_put;
    end else if (wr_done) begin
      s2_valid_d = 1'b0;
    end

    if (wr_done && (count_q != 8'hff)) begin
      count_d = count_q + 8'd1;
    end

    // Changing the problem mid-flight would corrupt pending lookups, so it is refused.
    if (problem_ld) begin
      if (busy_int || (problem_in == 2'd3)) begin
        err_d = 1'b1;
      end else begin
        problem_d = problem_in;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      s1_valid_q <= 1'b0;
      s1_idx_q   <= 3'd0;
      s1_dest_q  <= 3'd0;
      s2_valid_q <= 1'b0;
      s2_addr_q  <= 3'd0;
      s2_data_q  <= 8'd0;
      problem_q  <= 2'd0;
      err_q      <= 1'b0;
      count_q    <= 8'd0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_idx_q   <= s1_idx_d;
      s1_dest_q  <= s1_dest_d;
      s2_valid_q <= s2_valid_d;
      s2_addr_q  <= s2_addr_d;
      s2_data_q  <= s2_data_d;
      problem_q  <= problem_d;
      err_q      <= err_d;
      count_q    <= count_d;
    end
  end

  assign bus.wr_en   = s2_valid_q;
  assign bus.wr_addr = s2_addr_q;
  assign bus.wr_data = s2_data_q;
  assign problem     = problem_q;
  assign Num_put_idx = s1_idx_q;
  assign busy        = busy_int;
  assign err_problem = err_q;
  assign put_count   = count_q;

endmodule

// File: tb/tb_put_unit.sv
// Bench for put_unit: directed scenarios plus random traffic, checked against
// an in-flight queue model of accepted-but-unwritten entries.
module tb_put_unit;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       problem_ld;
  logic [1:0] problem_in;
  logic [1:0] problem;
  logic [2:0] Num_put_idx;
  logic [7:0] Num_to_put;
  logic       busy;
  logic       err_problem;
  logic [7:0] put_count;

  put_unit_if bus ();

  put_unit dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .bus         (bus),
    .problem_ld  (problem_ld),
    .problem_in  (problem_in),
    .problem     (problem),
    .Num_put_idx (Num_put_idx),
    .Num_to_put  (Num_to_put),
    .busy        (busy),
    .err_problem (err_problem),
    .put_count   (put_count)
  );

  always #5 Clk = ~Clk;

  // External constant table.
  function automatic logic [7:0] tbl(input logic [1:0] p, input logic [2:0] i);
    logic [7:0] r;
    r = 8'd0;
    case (p)
      2'd0: begin
        case (i)
          3'd0: r = 8'd0;
          3'd1: r = 8'd1;
          3'd2: r = 8'd4;
          3'd3: r = 8'd8;
          3'd4: r = 8'd10;
          3'd5: r = 8'd14;
          3'd6: r = 8'd128;
          default: r = 8'd200;
        endcase
      end
      2'd1: r = {5'd0, i} * 8'd3;
      2'd2: r = 8'h40 + {5'd0, i};
      default: r = 8'd0;
    endcase
    return r;
  endfunction

  assign Num_to_put = tbl(problem, Num_put_idx);

  typedef struct {
    logic [2:0] dest;
    logic [7:0] data;
    int         t;
  } ent_t;

  ent_t       q[$];
  int         errors = 0;
  int         checks = 0;
  int         edge_cnt = 0;
  logic [1:0] m_prob;
  logic       m_err;
  int         m_count;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: drive at negedge, check outputs, advance the model, step to next negedge.
  task automatic cycle(input logic v, input logic [2:0] idx, input logic [2:0] dest,
                       input logic wrdy, input logic pld, input logic [1:0] pin);
    logic exp_wr_en, exp_rdy, exp_busy;
    ent_t e;
    bus.req_valid = v;
    bus.req_idx   = idx;
    bus.req_dest  = dest;
    bus.wr_ready  = wrdy;
    problem_ld    = pld;
    problem_in    = pin;
    #1;
    exp_busy  = (q.size() != 0);
    // The oldest entry is in the write stage once it has been in flight for two edges.
    exp_wr_en = (q.size() != 0) && (q[0].t < edge_cnt - 1);
    exp_rdy   = (q.size() < 2) || wrdy;
    chk("req_ready", bus.req_ready, exp_rdy);
    chk("busy", busy, exp_busy);
    chk("wr_en", bus.wr_en, exp_wr_en);
    chk("problem", problem, m_prob);
    chk("err_problem", err_problem, m_err);
    chk("put_count", put_count, m_count);
    if (exp_wr_en) begin
      chk("wr_addr", bus.wr_addr, q[0].dest);
      chk("wr_data", bus.wr_data, q[0].data);
    end
    if (pld) begin
      if (exp_busy || pin == 2'd3) m_err = 1'b1;
      else m_prob = pin;
    end
    if (exp_wr_en && wrdy) begin
      void'(q.pop_front());
      if (m_count < 255) m_count++;
    end
    if (v && exp_rdy) begin
      e.dest = dest;
      e.data = tbl(m_prob, idx);
      e.t    = edge_cnt;
      q.push_back(e);
    end
    @(posedge Clk);
    edge_cnt++;
    @(negedge Clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 3'd0, 3'd0, 1'b1, 1'b0, 2'd0);
  endtask

  task automatic do_reset(input logic wrdy);
    Reset         = 1'b1;
    bus.req_valid = 1'b1;
    bus.wr_ready  = wrdy;
    problem_ld    = 1'b0;
    #1;
    chk("rst_req_ready", bus.req_ready, 1'b0);
    @(posedge Clk);
    edge_cnt++;
    q.delete();
    m_prob  = 2'd0;
    m_err   = 1'b0;
    m_count = 0;
    @(negedge Clk);
    Reset         = 1'b0;
    bus.req_valid = 1'b0;
    bus.wr_ready  = 1'b1;
    #1;
    chk("rst_req_ready_after", bus.req_ready, 1'b1);
    chk("rst_wr_en", bus.wr_en, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_problem", problem, 2'd0);
    chk("rst_count", put_count, 8'd0);
    chk("rst_err", err_problem, 1'b0);
    chk("rst_wr_addr", bus.wr_addr, 3'd0);
    chk("rst_wr_data", bus.wr_data, 8'd0);
    chk("rst_idx", Num_put_idx, 3'd0);
  endtask

  initial begin
    Reset = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_idx = 3'd0;
    bus.req_dest = 3'd0;
    bus.wr_ready = 1'b0;
    problem_ld = 1'b0;
    problem_in = 2'd0;
    m_prob = 2'd0;
    m_err = 1'b0;
    m_count = 0;
    @(negedge Clk);
    do_reset(1'b0);

    // Single request.
    cycle(1'b1, 3'd5, 3'd3, 1'b1, 1'b0, 2'd0);
    cycle(1'b0, 3'd0, 3'd0, 1'b1, 1'b0, 2'd0);
    chk("single_wr_en", bus.wr_en, 1'b1);
    chk("single_addr", bus.wr_addr, 3'd3);
    chk("single_data", bus.wr_data, 8'd14);
    idle(2);
    chk("single_cnt", put_count, 8'd1);

    // Problem switch.
    cycle(1'b0, 3'd0, 3'd0, 1'b1, 1'b1, 2'd1);
    cycle(1'b1, 3'd5, 3'd0, 1'b1, 1'b0, 2'd0);
    cycle(1'b0, 3'd0, 3'd0, 1'b1, 1'b0, 2'd0);
    chk("switch_data1", bus.wr_data, 8'd15);
    idle(1);
    cycle(1'b0, 3'd0, 3'd0, 1'b1, 1'b1, 2'd2);
    cycle(1'b1, 3'd2, 3'd1, 1'b1, 1'b0, 2'd0);
    cycle(1'b0, 3'd0, 3'd0, 1'b1, 1'b0, 2'd0);
    chk("switch_data2", bus.wr_data, 8'h42);
    idle(2);

    // Coincident load and accept while idle: entry uses the new problem.
    cycle(1'b1, 3'd4, 3'd6, 1'b1, 1'b1, 2'd0);
    cycle(1'b0, 3'd0, 3'd0, 1'b1, 1'b0, 2'd0);
    chk("coinc_data", bus.wr_data, 8'd10);
    idle(2);

    // Back-to-back with a three-cycle stall.
    cycle(1'b1, 3'd1, 3'd0, 1'b1, 1'b0, 2'd0);
    cycle(1'b1, 3'd3, 3'd1, 1'b1, 1'b0, 2'd0);
    cycle(1'b1, 3'd4, 3'd2, 1'b1, 1'b0, 2'd0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 3'd6, 3'd3, 1'b0, 1'b0, 2'd0);
    cycle(1'b1, 3'd6, 3'd3, 1'b1, 1'b0, 2'd0);
    idle(4);
    chk("b2b_drained", busy, 1'b0);

    // Illegal problem loads.
    do_reset(1'b1);
    cycle(1'b1, 3'd0, 3'd0, 1'b1, 1'b0, 2'd0);
    cycle(1'b0, 3'd0, 3'd0, 1'b1, 1'b1, 2'd2);
    idle(3);
    chk("ill_busy_err", err_problem, 1'b1);
    chk("ill_busy_prob", problem, 2'd0);
    do_reset(1'b1);
    cycle(1'b0, 3'd0, 3'd0, 1'b1, 1'b1, 2'd3);
    idle(3);
    chk("ill_3_err", err_problem, 1'b1);
    chk("ill_3_prob", problem, 2'd0);
    cycle(1'b0, 3'd0, 3'd0, 1'b1, 1'b1, 2'd1);
    chk("ill_sticky", err_problem, 1'b1);

    // Saturation.
    do_reset(1'b1);
    for (int i = 0; i < 262; i++)
      cycle(1'b1, 3'($urandom), 3'($urandom), 1'b1, 1'b0, 2'd0);
    idle(3);
    chk("sat_count", put_count, 8'd255);

    // Random traffic.
    do_reset(1'b1);
    for (int i = 0; i < 400; i++)
      cycle(1'($urandom_range(0, 1)), 3'($urandom), 3'($urandom),
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0), 2'($urandom));
    idle(4);

    // Reset with both stages full.
    cycle(1'b1, 3'd1, 3'd1, 1'b0, 1'b0, 2'd0);
    cycle(1'b1, 3'd2, 3'd2, 1'b0, 1'b0, 2'd0);
    chk("full_busy", busy, 1'b1);
    do_reset(1'b0);
    idle(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
